// File: rtl/sc_shiftcmd_ctrl.sv
// -----------------------------------------------------------------------------
// sc_shiftcmd_ctrl
//   Command stage in front of the saturating position shift register.
//   Turns two raw active-low push buttons into single-cycle shift commands,
//   adds auto-repeat while a button is held, and issues the one-cycle load
//   strobe carrying the initial position after reset or restart.
//
// Ports
//   SC_RegSHIFTER_P2_CLOCK_50      in   1          system clock, rising edge
//   SC_RegSHIFTER_P2_RESET_InHigh  in   1          asynchronous reset, active-high
//   SC_ShiftCMD_left_InLow         in   1          raw left button, active-low, async
//   SC_ShiftCMD_right_InLow        in   1          raw right button, active-low, async
//   SC_ShiftCMD_restart_InLow      in   1          synchronous restart, active-low, level
//   SC_ShiftCMD_load_OutLow        out  1          load strobe to shifter, active-low
//   SC_ShiftCMD_shiftselection_Out out  2          01 left, 10 right, 00 hold
//   SC_ShiftCMD_data_OutBUS        out  DATAWIDTH  value loaded by the strobe
// -----------------------------------------------------------------------------
module sc_shiftcmd_ctrl #(
  parameter int unsigned          DATAWIDTH       = 8,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE      = {{(DATAWIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned          DEBOUNCE_CYCLES = 250000,
  parameter int unsigned          REPEAT_DELAY    = 25000000,
  parameter int unsigned          REPEAT_PERIOD   = 10000000
) (
  input  logic                 SC_RegSHIFTER_P2_CLOCK_50,
  input  logic                 SC_RegSHIFTER_P2_RESET_InHigh,
  input  logic                 SC_ShiftCMD_left_InLow,
  input  logic                 SC_ShiftCMD_right_InLow,
  input  logic                 SC_ShiftCMD_restart_InLow,
  output logic                 SC_ShiftCMD_load_OutLow,
  output logic [1:0]           SC_ShiftCMD_shiftselection_Out,
  output logic [DATAWIDTH-1:0] SC_ShiftCMD_data_OutBUS
);

  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned ArmW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax);

  localparam logic [DebW-1:0] DebLast    = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ArmW-1:0] ArmFull    = ArmW'(DEBOUNCE_CYCLES);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelLeft  = 2'b01;
  localparam logic [1:0] SelRight = 2'b10;

  typedef enum logic [1:0] {StInit, StIdle, StHold, StRepeat} stateT;

  // Button index 0 = left, 1 = right. All levels kept in raw polarity (1 = released).
  logic [1:0]           sync1Q, sync2Q;
  logic [1:0]           debQ, debD;
  logic [1:0][DebW-1:0] debCntQ, debCntD;
  logic [ArmW-1:0]      armCntQ, armCntD;
  logic                 armed;

  stateT           stateQ, stateD;
  logic            dirQ, dirD;      // 0 = left, 1 = right
  logic [RepW-1:0] repCntQ, repCntD;
  logic            loadQ, loadD;
  logic [1:0]      selQ, selD;

  logic leftP, rightP, dirP, oppP;
  logic [1:0] dirSel;

  // ---------------------------------------------------------------------------
  // Input path: synchronizers, debouncers, re-arm qualifier
  // ---------------------------------------------------------------------------
  always_ff @(posedge SC_RegSHIFTER_P2_CLOCK_50 or posedge SC_RegSHIFTER_P2_RESET_InHigh) begin
    if (SC_RegSHIFTER_P2_RESET_InHigh) begin
      sync1Q  <= 2'b11;
      sync2Q  <= 2'b11;
      debQ    <= 2'b11;
      debCntQ <= '0;
      armCntQ <= '0;
    end else begin
      sync1Q  <= {SC_ShiftCMD_right_InLow, SC_ShiftCMD_left_InLow};
      sync2Q  <= sync1Q;
      debQ    <= debD;
      debCntQ <= debCntD;
      armCntQ <= armCntD;
    end
  end

  always_comb begin
    debD    = debQ;
    debCntD = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2Q[i] != debQ[i]) begin
        // The level flips on the sample that would bring the count to DEBOUNCE_CYCLES.
        if (debCntQ[i] == DebLast) begin
          debD[i]    = sync2Q[i];
          debCntD[i] = '0;
        end else begin
          debCntD[i] = debCntQ[i] + 1'b1;
        end
      end
    end
  end

  // A new pulse is only allowed once both buttons have been seen released for a full
  // debounce window. Counting both synchronizer stages keeps the reset-forced "released"
  // sync values from arming the block while a button is physically still held; the
  // count holds (not clears) on raw noise so a debounced press still sees it armed.
  always_comb begin
    armCntD = armCntQ;
    if (debQ != 2'b11) begin
      armCntD = '0;
    end else if (sync1Q == 2'b11 && sync2Q == 2'b11 && armCntQ != ArmFull) begin
      armCntD = armCntQ + 1'b1;
    end
  end

  assign armed = (armCntQ == ArmFull);

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  assign leftP  = ~debQ[0];
  assign rightP = ~debQ[1];
  assign dirP   = dirQ ? rightP : leftP;
  assign oppP   = dirQ ? leftP : rightP;
  assign dirSel = dirQ ? SelRight : SelLeft;

  always_ff @(posedge SC_RegSHIFTER_P2_CLOCK_50 or posedge SC_RegSHIFTER_P2_RESET_InHigh) begin
    if (SC_RegSHIFTER_P2_RESET_InHigh) begin
      stateQ  <= StInit;
      dirQ    <= 1'b0;
      repCntQ <= '0;
      loadQ   <= 1'b1;
      selQ    <= SelHold;
    end else begin
      stateQ  <= stateD;
      dirQ    <= dirD;
      repCntQ <= repCntD;
      loadQ   <= loadD;
      selQ    <= selD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    dirD    = dirQ;
    repCntD = repCntQ;
    loadD   = 1'b1;
    selD    = SelHold;
    if (!SC_ShiftCMD_restart_InLow) begin
      // Restart performs the INIT load directly, once per cycle it is held low.
      loadD   = 1'b0;
      stateD  = StIdle;
      repCntD = '0;
    end else begin
      unique case (stateQ)
        StInit: begin
          loadD  = 1'b0;
          stateD = StIdle;
        end
        StIdle: begin
          if (armed && leftP && !rightP) begin
            selD    = SelLeft;
            dirD    = 1'b0;
            stateD  = StHold;
            repCntD = '0;
          end else if (armed && rightP && !leftP) begin
            selD    = SelRight;
            dirD    = 1'b1;
            stateD  = StHold;
            repCntD = '0;
          end
        end
        StHold: begin
          if (!dirP || oppP) begin
            stateD = StIdle;
          end else if (repCntQ == DelayLast) begin
            selD    = dirSel;
            stateD  = StRepeat;
            repCntD = '0;
          end else begin
            repCntD = repCntQ + 1'b1;
          end
        end
        StRepeat: begin
          if (!dirP || oppP) begin
            stateD = StIdle;
          end else if (repCntQ == PeriodLast) begin
            selD    = dirSel;
            repCntD = '0;
          end else begin
            repCntD = repCntQ + 1'b1;
          end
        end
        default: stateD = StInit;
      endcase
    end
  end

  assign SC_ShiftCMD_load_OutLow        = loadQ;
  assign SC_ShiftCMD_shiftselection_Out = selQ;
  // The load value never changes, so no register is needed to hold it.
  assign SC_ShiftCMD_data_OutBUS        = INIT_VALUE;

endmodule

// File: tb/tb_sc_shiftcmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sc_shiftcmd_ctrl
//   Directed bench for sc_shiftcmd_ctrl with short debounce/repeat timings.
//   A small saturating shifter model (01..08) sits on the outputs so the
//   walk/saturation of the chained system can be observed.
// -----------------------------------------------------------------------------
module tb_sc_shiftcmd_ctrl;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic          leftN;
  logic          rightN;
  logic          restartN;
  logic          loadN;
  logic [1:0]    sel;
  logic [DW-1:0] data;

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;

  int         pulseCyc[$];
  logic [1:0] pulseSel[$];
  int         loadCyc[$];
  int         overlapCnt = 0;
  int         illegalCnt = 0;
  logic [7:0] pos = 8'h00;

  sc_shiftcmd_ctrl #(
    .DATAWIDTH      (DW),
    .INIT_VALUE     (8'h01),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .SC_RegSHIFTER_P2_CLOCK_50     (clk),
    .SC_RegSHIFTER_P2_RESET_InHigh (rst),
    .SC_ShiftCMD_left_InLow        (leftN),
    .SC_ShiftCMD_right_InLow       (rightN),
    .SC_ShiftCMD_restart_InLow     (restartN),
    .SC_ShiftCMD_load_OutLow       (loadN),
    .SC_ShiftCMD_shiftselection_Out(sel),
    .SC_ShiftCMD_data_OutBUS       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shifter: load, shift left/right, saturate at 08 / 01.
  always @(posedge clk) begin
    if (!loadN) pos <= data;
    else if (sel == 2'b01 && pos != 8'h08) pos <= pos << 1;
    else if (sel == 2'b10 && pos != 8'h01) pos <= pos >> 1;
  end

  always @(negedge clk) begin
    if (sel != 2'b00) begin
      pulseCyc.push_back(cyc);
      pulseSel.push_back(sel);
    end
    if (!loadN) loadCyc.push_back(cyc);
    if (!loadN && sel != 2'b00) overlapCnt++;
    if (sel == 2'b11) illegalCnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearCapture();
    pulseCyc.delete();
    pulseSel.delete();
    loadCyc.delete();
  endtask

  // Press one button at the current edge, hold 8 cycles, release, let it settle.
  task automatic tapButton(input bit right, output int k);
    if (right) rightN = 1'b0;
    else leftN = 1'b0;
    k = cyc;
    tick(8);
    if (right) rightN = 1'b1;
    else leftN = 1'b1;
    tick(20);
  endtask

  task automatic expectSingle(input string tag, input int expCyc, input logic [1:0] expSel);
    checkEq({tag, "_count"}, pulseCyc.size(), 1);
    if (pulseCyc.size() > 0) begin
      checkEq({tag, "_cycle"}, pulseCyc[0], expCyc);
      checkEq({tag, "_sel"}, 32'(pulseSel[0]), 32'(expSel));
    end
  endtask

  initial begin
    int k;
    int p;
    int q;
    int e0;
    logic [7:0] walk [4];
    walk = '{8'h02, 8'h04, 8'h08, 8'h08};

    rst      = 1'b0;
    leftN    = 1'b1;
    rightN   = 1'b1;
    restartN = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    checkEq("rst_load", 32'(loadN), 32'h1);
    checkEq("rst_sel", 32'(sel), 32'h0);
    checkEq("rst_data", 32'(data), 32'h01);

    // 1: reset release -> one load cycle, then idle.
    tick(2);
    clearCapture();
    rst = 1'b0;
    e0  = cyc;
    tick(12);
    checkEq("t1_load_count", loadCyc.size(), 1);
    if (loadCyc.size() > 0) checkEq("t1_load_cycle", loadCyc[0], e0 + 1);
    checkEq("t1_no_shift", pulseCyc.size(), 0);
    checkEq("t1_pos", 32'(pos), 32'h01);

    // 2: single left press, then single right press.
    clearCapture();
    tapButton(1'b0, k);
    expectSingle("t2_left", k + 7, 2'b01);
    checkEq("t2_left_pos", 32'(pos), 32'h02);
    clearCapture();
    tapButton(1'b1, k);
    expectSingle("t2_right", k + 7, 2'b10);
    checkEq("t2_right_pos", 32'(pos), 32'h01);

    // 3: left held -> first pulse P, repeats at P+10, P+15, ... ; release at P+38.
    clearCapture();
    leftN = 1'b0;
    k = cyc;
    p = k + 7;
    tick(45);
    leftN = 1'b1;
    tick(20);
    checkEq("t3_count", pulseCyc.size(), 8);
    for (int i = 0; i < 8 && i < pulseCyc.size(); i++) begin
      checkEq($sformatf("t3_pulse%0d_cycle", i), pulseCyc[i], (i == 0) ? p : p + 5 + 5 * i);
      checkEq($sformatf("t3_pulse%0d_sel", i), 32'(pulseSel[i]), 32'h1);
    end
    checkEq("t3_pos_saturated", 32'(pos), 32'h08);

    // 4: glitchy left never qualifies; both pressed never pulses, nor does the leftover one.
    clearCapture();
    repeat (6) begin
      leftN = 1'b0;
      tick(3);
      leftN = 1'b1;
      tick(1);
    end
    tick(15);
    checkEq("t4_glitch_none", pulseCyc.size(), 0);
    clearCapture();
    leftN  = 1'b0;
    rightN = 1'b0;
    tick(12);
    rightN = 1'b1;
    tick(15);
    leftN = 1'b1;
    tick(20);
    checkEq("t4_both_none", pulseCyc.size(), 0);

    // 5: one-cycle restart during REPEAT.
    clearCapture();
    leftN = 1'b0;
    k = cyc;
    p = k + 7;
    tick(19);
    restartN = 1'b0;
    tick(1);
    restartN = 1'b1;
    tick(18);
    leftN = 1'b1;
    tick(20);
    checkEq("t5_count", pulseCyc.size(), 2);
    if (pulseCyc.size() > 0) checkEq("t5_first_cycle", pulseCyc[0], p);
    if (pulseCyc.size() > 1) checkEq("t5_repeat_cycle", pulseCyc[1], p + 10);
    checkEq("t5_load_count", loadCyc.size(), 1);
    if (loadCyc.size() > 0) checkEq("t5_load_cycle", loadCyc[0], p + 13);
    checkEq("t5_pos_reloaded", 32'(pos), 32'h01);
    clearCapture();
    tapButton(1'b0, k);
    expectSingle("t5_repress", k + 7, 2'b01);
    checkEq("t5_repress_pos", 32'(pos), 32'h02);

    // 6: reset while a left pulse is on the outputs, left still held.
    clearCapture();
    leftN = 1'b0;
    k = cyc;
    tick(7);
    checkEq("t6_pre_sel", 32'(sel), 32'h1);
    rst = 1'b1;
    #1;
    checkEq("t6_async_sel", 32'(sel), 32'h0);
    checkEq("t6_async_load", 32'(loadN), 32'h1);
    checkEq("t6_async_data", 32'(data), 32'h01);
    tick(2);
    clearCapture();
    rst = 1'b0;
    q = cyc;
    tick(30);
    checkEq("t6_load_count", loadCyc.size(), 1);
    if (loadCyc.size() > 0) checkEq("t6_load_cycle", loadCyc[0], q + 1);
    checkEq("t6_held_no_shift", pulseCyc.size(), 0);
    checkEq("t6_pos_loaded", 32'(pos), 32'h01);
    leftN = 1'b1;
    tick(20);
    checkEq("t6_release_no_shift", pulseCyc.size(), 0);
    for (int i = 0; i < 4; i++) begin
      clearCapture();
      tapButton(1'b0, k);
      expectSingle($sformatf("t6_walk%0d", i), k + 7, 2'b01);
      checkEq($sformatf("t6_walk%0d_pos", i), 32'(pos), 32'(walk[i]));
    end

    checkEq("load_sel_overlap", overlapCnt, 0);
    checkEq("sel_11_seen", illegalCnt, 0);
    checkEq("data_const", 32'(data), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
